// File: rtl/spi_msg_mailbox.sv
// Message mailbox between the Wishbone front-end (port A) and the SPI engine (port B).
// Each slot cycles FREE -> PENDING -> ACTIVE -> DONE -> FREE; a round-robin scanner offers pending slots.
module spi_msg_mailbox #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_stb,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W+1:0] a_rdata,
  output logic              a_ack,
  output logic              a_err,
  output logic              b_valid,
  output logic [ADDR_W-1:0] b_slot,
  output logic [DATA_W-1:0] b_data,
  input  logic              b_take,
  input  logic              b_done,
  input  logic [ADDR_W-1:0] b_done_slot,
  input  logic [DATA_W-1:0] b_done_data,
  output logic              b_err,
  output logic [ADDR_W:0]   pending_cnt,
  output logic [ADDR_W:0]   done_cnt,
  output logic              irq
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    PENDING = 2'b01,
    ACTIVE  = 2'b10,
    DONE    = 2'b11
  } slot_state_e;

  slot_state_e       state_q [DEPTH];
  slot_state_e       state_d [DEPTH];
  logic [DATA_W-1:0] mem_q   [DEPTH];

  logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [DATA_W+1:0] a_rdata_q, a_rdata_d;
  logic              a_ack_q, a_ack_d;
  logic              a_err_q, a_err_d;
  logic              b_valid_q, b_valid_d;
  logic [ADDR_W-1:0] b_slot_q, b_slot_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              b_err_q, b_err_d;
  logic [ADDR_W:0]   pending_cnt_q, pending_cnt_d;
  logic [ADDR_W:0]   done_cnt_q, done_cnt_d;
  logic              irq_q, irq_d;

  slot_state_e a_cur, d_cur, s_cur;
  logic        accept, a_wr_ok, a_rd_clr, take, done_ok;

  // All event qualifiers look at pre-edge state, so they never target the same slot twice.
  always_comb begin
    a_cur    = state_q[a_addr];
    d_cur    = state_q[b_done_slot];
    s_cur    = state_q[scan_ptr_q];
    accept   = a_stb & ~a_ack_q;
    a_wr_ok  = accept & a_we & (a_cur == FREE);
    a_rd_clr = accept & ~a_we & (a_cur == DONE);
    take     = b_valid_q & b_take;
    done_ok  = b_done & (d_cur == ACTIVE);

    for (int i = 0; i < DEPTH; i++) state_d[i] = state_q[i];
    if (a_wr_ok)  state_d[a_addr]      = PENDING;
    if (a_rd_clr) state_d[a_addr]      = FREE;
    if (take)     state_d[b_slot_q]    = ACTIVE;
    if (done_ok)  state_d[b_done_slot] = DONE;

    a_ack_d   = accept;
    a_err_d   = accept & a_we & (a_cur != FREE);
    a_rdata_d = (accept & ~a_we) ? {a_cur, mem_q[a_addr]} : a_rdata_q;
    b_err_d   = b_done & (d_cur != ACTIVE);

    scan_ptr_d = scan_ptr_q;
    b_valid_d  = b_valid_q;
    b_slot_d   = b_slot_q;
    b_data_d   = b_data_q;
    if (take) begin
      b_valid_d  = 1'b0;
      scan_ptr_d = b_slot_q + 1'b1;
    end else if (!b_valid_q) begin
      if (s_cur == PENDING) begin
        b_valid_d = 1'b1;
        b_slot_d  = scan_ptr_q;
        b_data_d  = mem_q[scan_ptr_q];
      end else begin
        scan_ptr_d = scan_ptr_q + 1'b1;
      end
    end

    pending_cnt_d = pending_cnt_q + (ADDR_W+1)'(a_wr_ok) - (ADDR_W+1)'(take);
    done_cnt_d    = done_cnt_q + (ADDR_W+1)'(done_ok) - (ADDR_W+1)'(a_rd_clr);
    irq_d         = (done_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= FREE;
      scan_ptr_q    <= '0;
      a_rdata_q     <= '0;
      a_ack_q       <= 1'b0;
      a_err_q       <= 1'b0;
      b_valid_q     <= 1'b0;
      b_slot_q      <= '0;
      b_data_q      <= '0;
      b_err_q       <= 1'b0;
      pending_cnt_q <= '0;
      done_cnt_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      scan_ptr_q    <= scan_ptr_d;
      a_rdata_q     <= a_rdata_d;
      a_ack_q       <= a_ack_d;
      a_err_q       <= a_err_d;
      b_valid_q     <= b_valid_d;
      b_slot_q      <= b_slot_d;
      b_data_q      <= b_data_d;
      b_err_q       <= b_err_d;
      pending_cnt_q <= pending_cnt_d;
      done_cnt_q    <= done_cnt_d;
      irq_q         <= irq_d;
    end
  end

  // Payload store has no reset; a reset cycle only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (a_wr_ok) mem_q[a_addr]      <= a_wdata;
      if (done_ok) mem_q[b_done_slot] <= b_done_data;
    end
  end

  assign a_rdata     = a_rdata_q;
  assign a_ack       = a_ack_q;
  assign a_err       = a_err_q;
  assign b_valid     = b_valid_q;
  assign b_slot      = b_slot_q;
  assign b_data      = b_data_q;
  assign b_err       = b_err_q;
  assign pending_cnt = pending_cnt_q;
  assign done_cnt    = done_cnt_q;
  assign irq         = irq_q;
endmodule

// File: doc/spi_msg_mailbox.md
Name: spi_msg_mailbox

Overview:
- Parametrised, single-clock message mailbox between the Wishbone slave front-end (port A) and the SPI transfer engine (port B).
- Generalises the current dual-port message buffer:
  - configurable payload width and slot count;
  - explicit 4-state per-slot lifecycle;
  - hardware round-robin scanner that hands pending slots to the engine;
  - occupancy counters and a completion interrupt.

Parameters:
- DATA_W, 24, message payload width in bits (e.g. address[6:0], data[7:0], flags).
- ADDR_W, 8, slot index width; DEPTH = 2**ADDR_W slots.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- a_stb  in  1  port A request strobe.
- a_we  in  1  port A 1 = submit message, 0 = read slot.
- a_addr  in  ADDR_W  port A slot index.
- a_wdata  in  DATA_W  port A message payload.
- a_rdata  out  DATA_W+2  port A read result {state[1:0], payload}.
- a_ack  out  1  port A one-cycle acknowledge.
- a_err  out  1  port A error, valid only with a_ack.
- b_valid  out  1  a PENDING slot is offered to the engine.
- b_slot  out  ADDR_W  offered slot index.
- b_data  out  DATA_W  offered slot payload.
- b_take  in  1  engine accepts the offered slot.
- b_done  in  1  engine completion strobe.
- b_done_slot  in  ADDR_W  completed slot index.
- b_done_data  in  DATA_W  result payload (e.g. SPI read data).
- b_err  out  1  one-cycle pulse: b_done aimed at a non-ACTIVE slot.
- pending_cnt  out  ADDR_W+1  number of slots in PENDING.
- done_cnt  out  ADDR_W+1  number of slots in DONE.
- irq  out  1  level interrupt, high while done_cnt != 0.

Behaviour:
- Slot state encoding: FREE=00, PENDING=01, ACTIVE=10, DONE=11.
  - State is held in a flop array.
  - Payload is held in a DEPTH x DATA_W array.
- Reset (rst=1 at a clk edge):
  - all slots FREE; scan_ptr=0;
  - a_ack, a_err, a_rdata, b_valid, b_slot, b_data, b_err, counters and irq all 0;
  - payload array is not cleared;
  - reset mid-transaction aborts everything; no ack is issued for a request presented in the reset cycle.
- Port A acceptance: a request is accepted when a_stb=1 and a_ack=0.
  - a_ack pulses high exactly the following cycle, for exactly 1 cycle.
  - a_stb held high therefore yields one ack every 2 cycles.
- Port A write:
  - If the slot is FREE: payload <= a_wdata, state <= PENDING, a_err=0.
  - Otherwise: no change, a_err=1 with the ack.
- Port A read:
  - a_rdata <= {state, payload} as sampled in the accept cycle (pre-update); a_err=0.
  - If the slot is DONE, the slot becomes FREE in the same edge (read-to-clear).
  - Reading PENDING, ACTIVE or FREE has no side effect.
- Scanner (active while b_valid=0):
  - Each cycle, examine slot[scan_ptr].
  - If it is PENDING: b_valid<=1, b_slot<=scan_ptr, b_data<=payload.
  - Else: scan_ptr<=scan_ptr+1, wrapping DEPTH-1 -> 0.
  - Worst-case offer latency is DEPTH cycles.
- Offer hold: while b_valid=1, b_slot and b_data hold stable; the scanner stalls.
- Take: b_valid=1 and b_take=1 at an edge gives state[b_slot] <= ACTIVE, b_valid<=0, scan_ptr<=b_slot+1 (round-robin fairness). b_take while b_valid=0 is ignored.
- Completion: b_done=1 at an edge.
  - If slot[b_done_slot] is ACTIVE: payload <= b_done_data, state <= DONE.
  - Else: no change, b_err pulses 1 cycle later.
- Simultaneous events (all updates in one edge, both ports always serviced):
  - A write to slot X and B completion on slot Y!=X: both take effect.
  - Same slot: A write errors, because the slot is not FREE.
  - A read of a DONE slot and b_done on the same slot: read clears it; b_done errors.
  - A read and b_take on the same slot: A returns PENDING; the slot becomes ACTIVE.
  - b_take and b_done in the same cycle: both apply, to their own slots.
- Counters:
  - pending_cnt and done_cnt are registered and updated by the net +/-1 of all transitions in the edge, including simultaneous inc/dec.
  - No wrap is possible; the maximum is DEPTH.
  - irq is registered from the updated done_cnt.

Test Plan:
- Reset, then write slot 5 with 0x00A1B2 -> a_ack 1 cycle later with a_err=0. Within at most 6 cycles, b_valid=1, b_slot=5, b_data=0x00A1B2; pending_cnt=1.
- Second write to slot 5 while PENDING -> a_ack=1, a_err=1; payload unchanged; pending_cnt=1.
- b_take on slot 5, then b_done with slot 5 and data 0x0000FF -> state DONE, irq=1, done_cnt=1. A read of slot 5 -> a_rdata={11, 0x0000FF} and the slot becomes FREE; the next cycle irq=0.
- Slots 2, 200, 7 written while scan_ptr=0; engine takes each immediately -> offer order is 2, 7, 200 (round-robin). A further write to slot 3 is offered only after the pointer wraps past 255.
- b_done on FREE slot 9 -> b_err pulses 1 cycle, no state change. In the same cycle, an A write to slot 10 -> succeeds.
- rst asserted while slot 4 is ACTIVE and b_valid=1 -> next cycle all outputs 0, counters 0. A read of slot 4 afterwards -> state 00.
